// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send and
// shifts one command byte out on device clock falls, then checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_TICKS = 1200,
  parameter int TIMEOUT_TICKS = 180000,
  parameter int FILTER_LEN    = 8
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_ce,
  input  logic [1:0] i_ps2,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_dat_oe,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error
);

  localparam int MAXT = (INHIBIT_TICKS > TIMEOUT_TICKS) ? INHIBIT_TICKS : TIMEOUT_TICKS;
  localparam int CW   = $clog2(MAXT) + 1;
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_TICKS - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t                r_state;
  logic [FILTER_LEN-1:0] r_filt;
  logic                  r_lvl;
  logic                  r_dat;
  logic [CW-1:0]         r_cnt;
  logic [3:0]            r_bitcnt;
  logic [9:0]            r_shift;
  logic                  r_clk_oe;
  logic                  r_dat_oe;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic                  w_fall;

  // A fall is reported on the tick where the filter has just filled with zeros
  // while the accepted level is still high; the level itself drops on that tick.
  assign w_fall = r_lvl && (r_filt == '0);

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_filt   <= '1;
      r_lvl    <= 1'b1;
      r_dat    <= 1'b1;
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      if (i_ce) begin
        r_filt <= {r_filt[FILTER_LEN-2:0], i_ps2[0]};
        if (&r_filt)
          r_lvl <= 1'b1;
        else if (r_filt == '0)
          r_lvl <= 1'b0;
        r_dat <= i_ps2[1];

        case (r_state)
          S_IDLE: begin
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_busy   <= 1'b0;
            if (i_start) begin
              r_shift  <= {1'b1, ~^i_data, i_data};
              r_busy   <= 1'b1;
              r_clk_oe <= 1'b1;
              r_cnt    <= '0;
              r_state  <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == INH_LAST) begin
              r_dat_oe <= 1'b1;
              r_state  <= S_REQ;
            end
          end
          S_REQ: begin
            r_clk_oe <= 1'b0;
            r_bitcnt <= '0;
            r_cnt    <= '0;
            r_state  <= S_SEND;
          end
          S_SEND, S_ACK, S_WAIT_IDLE: begin
            if (r_state == S_WAIT_IDLE && r_lvl && r_dat) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else if (w_fall && r_state != S_WAIT_IDLE) begin
              r_cnt <= '0;
              if (r_state == S_SEND) begin
                // Data only moves right after a fall, while the device holds clock low.
                r_dat_oe <= ~r_shift[0];
                r_shift  <= {1'b0, r_shift[9:1]};
                r_bitcnt <= r_bitcnt + 1'b1;
                if (r_bitcnt == 4'd9)
                  r_state <= S_ACK;
              end else if (r_dat) begin
                r_error  <= 1'b1;
                r_busy   <= 1'b0;
                r_dat_oe <= 1'b0;
                r_state  <= S_IDLE;
              end else begin
                r_state <= S_WAIT_IDLE;
              end
            end else if (r_cnt == TO_LAST) begin
              r_clk_oe <= 1'b0;
              r_dat_oe <= 1'b0;
              r_error  <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_ps2_clk_oe = r_clk_oe;
  assign o_ps2_dat_oe = r_dat_oe;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_error      = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a tick-driven PS/2 device model on open-drain wires,
// a vector table of bytes/ACK choices, and hand-written corner sequences.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 300;
  localparam int FLT = 4;

  logic       clk = 1'b0;
  logic       i_reset_n;
  logic       i_ce = 1'b0;
  logic       i_start;
  logic [7:0] i_data;
  logic [1:0] i_ps2;
  logic       o_ps2_clk_oe, o_ps2_dat_oe, o_busy, o_done, o_error;

  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic glitch  = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int mon_done = 0;
  int mon_err = 0;
  int mon_clkoe = 0;
  int cyc = 0;

  assign i_ps2[0] = ~o_ps2_clk_oe & dev_clk & ~glitch;
  assign i_ps2[1] = ~o_ps2_dat_oe & dev_dat;

  ps2_host_tx #(.INHIBIT_TICKS(INH), .TIMEOUT_TICKS(TMO), .FILTER_LEN(FLT)) dut (
    .i_clock     (clk),
    .i_reset_n   (i_reset_n),
    .i_ce        (i_ce),
    .i_ps2       (i_ps2),
    .o_ps2_clk_oe(o_ps2_clk_oe),
    .o_ps2_dat_oe(o_ps2_dat_oe),
    .i_start     (i_start),
    .i_data      (i_data),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error)
  );

  always #5 clk = ~clk;

  // Clock enable active two cycles out of three.
  always @(negedge clk) begin
    cyc  = cyc + 1;
    i_ce = (cyc % 3) != 2;
  end

  always @(negedge clk) begin
    if (o_done)  mon_done = mon_done + 1;
    if (o_error) mon_err  = mon_err + 1;
  end

  always @(posedge clk) begin
    if (i_ce && o_ps2_clk_oe) mon_clkoe = mon_clkoe + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    do @(posedge clk); while (i_ce !== 1'b1);
    #1;
  endtask

  task automatic wait_busy(input logic val, input string nm);
    int n = 0;
    while (o_busy !== val && n < 100) begin tick(); n++; end
    chk(nm, o_busy, val);
  endtask

  // Device: waits for request-to-send, then produces nclk clocks of 10 high / 10 low
  // ticks, sampling the data line at the end of each low phase.
  task automatic dev_frame(input int nclk, input bit ack, input bit glt,
                           output logic [10:0] bits);
    int n = 0;
    bits = '0;
    while (!(o_ps2_clk_oe == 1'b0 && o_ps2_dat_oe == 1'b1) && n < 200) begin
      tick(); n++;
    end
    chk("rts_seen", (n < 200), 1);
    if (n >= 200) return;
    for (int k = 0; k < nclk; k++) begin
      if (glt && k == 3) begin
        repeat (3) tick();
        glitch = 1'b1;
        repeat (3) tick();
        glitch = 1'b0;
        repeat (4) tick();
      end else begin
        repeat (10) tick();
      end
      dev_clk = 1'b0;
      if (k == 10 && ack) dev_dat = 1'b0;
      repeat (10) tick();
      bits[k] = i_ps2[1];
      dev_clk = 1'b1;
    end
    repeat (5) tick();
    dev_dat = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    logic       par;
    int         ndone;
    int         nerr;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [10:0] bits, bits2;
    int d0, e0, c0, n;

    tbl[0] = '{8'hED, 1'b1, 1'b1, 1, 0};
    tbl[1] = '{8'h00, 1'b1, 1'b1, 1, 0};
    tbl[2] = '{8'hFF, 1'b1, 1'b1, 1, 0};
    tbl[3] = '{8'h01, 1'b1, 1'b0, 1, 0};
    tbl[4] = '{8'hA5, 1'b0, 1'b1, 0, 1};

    i_reset_n = 1'b0;
    i_start   = 1'b0;
    i_data    = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_clk_oe", o_ps2_clk_oe, 0);
    chk("rst_dat_oe", o_ps2_dat_oe, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_error", o_error, 0);
    i_reset_n = 1'b1;
    repeat (6) tick();

    for (int i = 0; i < 5; i++) begin
      d0 = mon_done; e0 = mon_err; c0 = mon_clkoe;
      i_data  = tbl[i].data;
      i_start = 1'b1;
      wait_busy(1'b1, "vec_accept");
      i_start = 1'b0;
      dev_frame(11, tbl[i].ack, 1'b0, bits);
      wait_busy(1'b0, "vec_idle");
      repeat (3) tick();
      chk($sformatf("vec%0d_data", i), bits[7:0], tbl[i].data);
      chk($sformatf("vec%0d_parity", i), bits[8], tbl[i].par);
      chk($sformatf("vec%0d_stop", i), bits[9], 1);
      chk($sformatf("vec%0d_done", i), mon_done - d0, tbl[i].ndone);
      chk($sformatf("vec%0d_error", i), mon_err - e0, tbl[i].nerr);
      chk($sformatf("vec%0d_clkoe_ticks", i), mon_clkoe - c0, INH + 1);
      chk($sformatf("vec%0d_lines", i), {o_ps2_clk_oe, o_ps2_dat_oe}, 0);
    end

    // Device never clocks: timeout counted from the tick that entered SEND.
    d0 = mon_done; e0 = mon_err;
    i_data  = 8'h12;
    i_start = 1'b1;
    wait_busy(1'b1, "tmo_accept");
    i_start = 1'b0;
    n = 0;
    while (o_ps2_clk_oe !== 1'b1 && n < 10) begin tick(); n++; end
    n = 0;
    while (o_ps2_clk_oe !== 1'b0 && n < 100) begin tick(); n++; end
    chk("tmo_clk_release", o_ps2_clk_oe, 0);
    n = 0;
    do begin tick(); n++; end while (o_error !== 1'b1 && n < TMO + 50);
    chk("tmo_ticks", n, TMO);
    chk("tmo_lines", {o_ps2_clk_oe, o_ps2_dat_oe}, 0);
    chk("tmo_busy", o_busy, 0);
    repeat (3) tick();
    chk("tmo_err_cnt", mon_err - e0, 1);
    chk("tmo_done_cnt", mon_done - d0, 0);

    // start held high over two transfers, data changed after acceptance, clock glitch.
    d0 = mon_done; e0 = mon_err;
    i_data  = 8'h3C;
    i_start = 1'b1;
    wait_busy(1'b1, "b2b_accept");
    i_data = 8'h55;
    dev_frame(11, 1'b1, 1'b0, bits);
    n = 0;
    while (o_done !== 1'b1 && n < 100) begin tick(); n++; end
    chk("b2b_done_seen", o_done, 1);
    chk("b2b_busy_at_done", o_busy, 0);
    tick();
    chk("b2b_restart_busy", o_busy, 1);
    chk("b2b_restart_clk_oe", o_ps2_clk_oe, 1);
    i_start = 1'b0;
    dev_frame(11, 1'b1, 1'b1, bits2);
    wait_busy(1'b0, "b2b_idle");
    repeat (3) tick();
    chk("b2b_first_data", bits[7:0], 8'h3C);
    chk("b2b_first_parity", bits[8], 1);
    chk("b2b_second_data", bits2[7:0], 8'h55);
    chk("b2b_second_parity", bits2[8], 1);
    chk("b2b_second_stop", bits2[9], 1);
    chk("b2b_done_cnt", mon_done - d0, 2);
    chk("b2b_err_cnt", mon_err - e0, 0);

    // Reset in the middle of the data bits, then a clean transfer.
    d0 = mon_done; e0 = mon_err;
    i_data  = 8'hA5;
    i_start = 1'b1;
    wait_busy(1'b1, "rst_mid_accept");
    i_start = 1'b0;
    dev_frame(4, 1'b1, 1'b0, bits);
    chk("rst_mid_busy_before", o_busy, 1);
    i_reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_lines", {o_ps2_clk_oe, o_ps2_dat_oe}, 0);
    chk("rst_mid_busy", o_busy, 0);
    i_reset_n = 1'b1;
    repeat (30) tick();
    chk("rst_mid_no_done", mon_done - d0, 0);
    chk("rst_mid_no_err", mon_err - e0, 0);
    i_data  = 8'hED;
    i_start = 1'b1;
    wait_busy(1'b1, "rst_next_accept");
    i_start = 1'b0;
    dev_frame(11, 1'b1, 1'b0, bits);
    wait_busy(1'b0, "rst_next_idle");
    repeat (3) tick();
    chk("rst_next_data", bits[7:0], 8'hED);
    chk("rst_next_parity", bits[8], 1);
    chk("rst_next_done", mon_done - d0, 1);
    chk("rst_next_err", mon_err - e0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
